// File: rtl/div_pkg.sv
// Shared width, operation encoding and FSM state types for the iterative divider.
package div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] partial_rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            quot_bit
);

    logic [XLEN:0] shifted;

    assign shifted  = {partial_rem, next_bit};
    assign quot_bit = (shifted >= {1'b0, divisor});
    // The low XLEN bits of the difference are exact, because the subtraction
    // is only taken when the full XLEN+1 bit value does not underflow.
    assign next_rem = quot_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Fixed-latency XLEN-cycle restoring divider for DIV/DIVU/REM/REMU with
// register-file write-back of the selected quotient or remainder.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            busy_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_sel_o,
    output logic [XLEN-1:0] wb_data_o
);

    localparam int               CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    div_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, divisor_reg;
    logic [4:0]      rd_reg;
    logic            is_rem_reg, neg_quo_reg, neg_rem_reg, div_zero_reg;
    logic            wb_en_reg;
    logic [4:0]      wb_sel_reg;
    logic [XLEN-1:0] wb_data_reg;

    logic            is_signed, dividend_neg, divisor_neg, last_iter;
    logic [XLEN-1:0] dividend_mag, divisor_mag;
    logic [XLEN-1:0] step_rem, quo_final, quo_signed, rem_signed, result;
    logic            step_bit;

    // Signed operations work on magnitudes; signs are re-applied at the end.
    assign is_signed    = (op_i == OP_DIV) || (op_i == OP_REM);
    assign dividend_neg = is_signed & rs1_data_i[XLEN-1];
    assign divisor_neg  = is_signed & rs2_data_i[XLEN-1];
    assign dividend_mag = dividend_neg ? -rs1_data_i : rs1_data_i;
    assign divisor_mag  = divisor_neg  ? -rs2_data_i : rs2_data_i;

    div_step #(.XLEN(XLEN)) u_step (
        .partial_rem (rem_reg),
        .next_bit    (quo_reg[XLEN-1]),
        .divisor     (divisor_reg),
        .next_rem    (step_rem),
        .quot_bit    (step_bit)
    );

    // The result is formed from the last iteration's combinational output so
    // write-back lands on the same edge that enters DONE.
    assign quo_final  = {quo_reg[XLEN-2:0], step_bit};
    assign quo_signed = div_zero_reg ? '1 : (neg_quo_reg ? -quo_final : quo_final);
    assign rem_signed = neg_rem_reg ? -step_rem : step_rem;
    assign result     = is_rem_reg ? rem_signed : quo_signed;

    assign last_iter = (state_reg == S_CALC) && (cnt_reg == LAST_ITER);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_i) state_next = S_CALC;
            S_CALC:  if (cnt_reg == LAST_ITER) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            rd_reg       <= '0;
            is_rem_reg   <= 1'b0;
            neg_quo_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            wb_en_reg    <= 1'b0;
            wb_sel_reg   <= '0;
            wb_data_reg  <= '0;
        end else begin
            wb_en_reg <= 1'b0;
            if (state_reg == S_IDLE && start_i) begin
                cnt_reg      <= '0;
                rem_reg      <= '0;
                quo_reg      <= dividend_mag;
                divisor_reg  <= divisor_mag;
                rd_reg       <= rd_i;
                is_rem_reg   <= (op_i == OP_REM) || (op_i == OP_REMU);
                neg_quo_reg  <= dividend_neg ^ divisor_neg;
                neg_rem_reg  <= dividend_neg;
                div_zero_reg <= (rs2_data_i == '0);
            end else if (state_reg == S_CALC) begin
                rem_reg <= step_rem;
                quo_reg <= quo_final;
                cnt_reg <= last_iter ? '0 : cnt_reg + 1'b1;
                if (last_iter) begin
                    wb_en_reg   <= (rd_reg != 5'd0);
                    wb_sel_reg  <= rd_reg;
                    wb_data_reg <= result;
                end
            end
        end
    end

    // Busy starts one edge after the start was taken and covers DONE, giving
    // exactly XLEN busy cycles per division.
    assign busy_o    = ((state_reg == S_CALC) && (cnt_reg != '0)) || (state_reg == S_DONE);
    assign wb_en_o   = wb_en_reg;
    assign wb_sel_o  = wb_sel_reg;
    assign wb_data_o = wb_data_reg;

endmodule

// File: tb/tb_div_unit.sv
// Table-driven bench for div_unit with a write-back scoreboard queue and
// hand-written reset and mid-calculation start sequences.
module tb_div_unit;
    import div_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [4:0]  rd_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        busy_o, wb_en_o;
    logic [4:0]  wb_sel_o;
    logic [31:0] wb_data_o;

    div_unit #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rd_i       (rd_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .busy_o     (busy_o),
        .wb_en_o    (wb_en_o),
        .wb_sel_o   (wb_sel_o),
        .wb_data_o  (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          mid;
    } vec_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   pulses   = 0;
        int   pulse_at = -1;
        int   busy_cnt = 0;
        exp_t e;
        @(negedge clk_i);
        start_i    = 1'b1;
        op_i       = v.op;
        rd_i       = v.rd;
        rs1_data_i = v.a;
        rs2_data_i = v.b;
        if (v.rd != 5'd0) exp_q.push_back('{sel: v.rd, data: v.exp});
        @(negedge clk_i);
        start_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        for (int k = 1; k <= 40; k++) begin
            start_i = v.mid && (k == 10);
            if (start_i) begin
                op_i = 2'($urandom_range(0, 3));
                rd_i = 5'd17;
            end
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (wb_en_o) begin
                pulses++;
                pulse_at = k;
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_sel", 64'(wb_sel_o), 64'(e.sel));
                    check("wb_data", 64'(wb_data_o), 64'(e.data));
                end
            end
        end
        start_i = 1'b0;
        if (v.rd != 5'd0) check("latency", 64'(pulse_at), 64'd32);
        check("pulse_count", 64'(pulses), (v.rd != 5'd0) ? 64'd1 : 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        check("hold_data", 64'(wb_data_o), 64'(v.exp));
        check("hold_sel", 64'(wb_sel_o), 64'(v.rd));
        check("pending", 64'(exp_q.size()), 64'd0);
        $display("op=%0d rd=%0d a=%08h b=%08h -> data=%08h exp=%08h wb_at=%0d busy=%0d",
                 v.op, v.rd, v.a, v.b, wb_data_o, v.exp, pulse_at, busy_cnt);
    endtask

    initial begin
        vecs[0]  = '{OP_DIVU, 5'd5,  32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{OP_REMU, 5'd5,  32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{OP_DIV,  5'd3,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        vecs[3]  = '{OP_REM,  5'd3,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
        vecs[4]  = '{OP_DIVU, 5'd8,  32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[5]  = '{OP_REMU, 5'd8,  32'h00001234,   32'd0,          32'h00001234,   1'b0};
        vecs[6]  = '{OP_DIV,  5'd9,  32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[7]  = '{OP_DIV,  5'd10, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0};
        vecs[8]  = '{OP_REM,  5'd10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b0};
        vecs[9]  = '{OP_DIV,  5'd11, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
        vecs[10] = '{OP_REM,  5'd11, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0};
        vecs[11] = '{OP_DIVU, 5'd12, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[12] = '{OP_REMU, 5'd12, 32'hFFFFFFFF,   32'd10,         32'd5,          1'b0};
        vecs[13] = '{OP_REM,  5'd13, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b0};
        vecs[14] = '{OP_DIV,  5'd13, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1'b0};
        vecs[15] = '{OP_DIV,  5'd14, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0};
        vecs[16] = '{OP_REM,  5'd31, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1};
        vecs[17] = '{OP_DIVU, 5'd0,  32'd100,        32'd7,          32'd14,         1'b0};

        rst_i = 1'b1; start_i = 1'b0; op_i = '0; rd_i = '0;
        rs1_data_i = '0; rs2_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_wb_en", 64'(wb_en_o), 64'd0);
        check("rst_wb_sel", 64'(wb_sel_o), 64'd0);
        check("rst_wb_data", 64'(wb_data_o), 64'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 18; i++) run_op(vecs[i]);

        // A result is left on the outputs, then reset hits at iteration 10.
        run_op('{OP_DIVU, 5'd6, 32'd1000, 32'd3, 32'd333, 1'b0});
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; rd_i = 5'd9;
        rs1_data_i = 32'd100; rs2_data_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_wb_en", 64'(wb_en_o), 64'd0);
        check("midrst_wb_sel", 64'(wb_sel_o), 64'd0);
        check("midrst_wb_data", 64'(wb_data_o), 64'd0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        $display("reset at iteration 10: busy=%0d wb_en=%0d sel=%0d data=%08h",
                 busy_o, wb_en_o, wb_sel_o, wb_data_o);
        run_op('{OP_REMU, 5'd7, 32'd100, 32'd7, 32'd2, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a division with the operands presented this cycle.
REQ-005 The block SHALL have port op_i, input, 2 bits: operation select, 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 The block SHALL have port rd_i, input, 5 bits: destination register index, carried through to write-back.
REQ-007 The block SHALL have port rs1_data_i, input, XLEN bits: the dividend.
REQ-008 The block SHALL have port rs2_data_i, input, XLEN bits: the divisor.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a division is in flight; upstream stalls on it.
REQ-010 The block SHALL have port wb_en_o, output, 1 bit: register-file write strobe.
REQ-011 The block SHALL have port wb_sel_o, output, 5 bits: register-file write select, driving the register file's sel_i.
REQ-012 The block SHALL have port wb_data_o, output, XLEN bits: register-file write data, driving the register file's data_i.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 The FSM SHALL move from IDLE to CALC on an edge where start_i=1, capturing op_i, rd_i and both operands at that edge; start_i SHALL be ignored in CALC and DONE.
REQ-015 CALC SHALL perform one restoring shift-subtract iteration per cycle for exactly XLEN cycles; an internal counter (0..XLEN-1) SHALL select the transition to DONE after the final iteration.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-017 Latency: for start sampled at edge E, wb_en_o SHALL be high only in the cycle between edges E+XLEN and E+XLEN+1, and busy_o SHALL be high from edge E+1 through that same cycle.
REQ-018 Latency SHALL be fixed; special cases (REQ-021, REQ-022) SHALL NOT shorten it.
REQ-019 Signed ops SHALL divide the operand magnitudes; a signed quotient SHALL be negated when the operand signs differ; a signed remainder SHALL take the sign of the dividend.
REQ-020 REM and REMU SHALL return the remainder; DIV and DIVU SHALL return the quotient.
REQ-021 For divisor zero, the quotient SHALL be all ones and the remainder SHALL equal the dividend, for both signed and unsigned ops.
REQ-022 For DIV/REM with dividend -2^(XLEN-1) and divisor -1, the quotient SHALL be -2^(XLEN-1) and the remainder SHALL be 0.
REQ-023 For rd=0, wb_en_o SHALL stay 0 in DONE while busy_o timing is unchanged.
REQ-024 wb_sel_o and wb_data_o SHALL update at entry to DONE and then hold until the next DONE.

Reset
REQ-025 On an edge with rst_i=1 the FSM SHALL go to IDLE, the counter SHALL clear to 0, and busy_o, wb_en_o, wb_sel_o and wb_data_o SHALL be 0.
REQ-026 rst_i SHALL take priority over start_i; an in-flight division SHALL be discarded and no wb_en_o pulse SHALL follow.

Structure
REQ-027 A package div_pkg SHALL hold XLEN, the op encoding enum and the FSM state enum.
REQ-028 One combinational sub-module, div_step, SHALL implement a single shift-subtract iteration (partial remainder, quotient bit); div_unit SHALL instance it once.

Verification
REQ-029 DIVU 100/7, rd=5 -> wb_en_o high exactly 32 cycles after the start edge, wb_sel_o=5, wb_data_o=14; REMU on the same operands -> 2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF.
REQ-031 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x1234/0 -> 0xFFFFFFFF; latency still 32.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
REQ-033 Start with rd=0 -> busy_o high for 32 cycles, no wb_en_o pulse; start_i pulsed mid-CALC -> ignored, one result only.
REQ-034 rst_i=1 at iteration 10 -> busy_o=0 and all outputs 0 the next cycle, no later wb_en_o; a new start immediately after reset completes normally.
